seq_divider: RTL and testbench

- Sequential radix-2 restoring divider: 2*WIDTH-bit unsigned dividend by WIDTH-bit unsigned divisor, giving WIDTH-bit quotient and remainder.
- It is the inverse datapath to the team's 16x16→32 multiplier, and its operand widths match that multiplier's product and operands.
- Produces one quotient bit per clock, with a valid/ready handshake on the input and output sides.
- Detects divide-by-zero and quotient overflow at acceptance.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 23 ++
 rtl/seq_divider.sv | 120 ++++++++++++
 tb/tb_seq_divider.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  // Wide enough for any WIDTH; slice down to the operand width where used.
  localparam logic [63:0] DIV_ERR_VALUE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] d_ext;
  logic           unused_rem_msb;

  // The incoming remainder is always below the divisor, so its MSB is never set.
  assign unused_rem_msb = rem[WIDTH];
  assign t        = {rem[WIDTH-1:0], next_bit};
  assign d_ext    = {1'b0, divisor};
  assign q_bit    = (t >= d_ext);
  assign rem_next = q_bit ? (t - d_ext) : t;

endmodule

// File: rtl/seq_divider.sv
// Sequential 2W/W unsigned divider, one quotient bit per clock, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | iterating, one quotient bit per cycle
//   DONE  | result presented, held until out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ERR_VAL = DIV_ERR_VALUE[WIDTH-1:0];

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .next_bit (lo[WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      rem       <= '0;
      lo        <= '0;
      q_acc     <= '0;
      dsr       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr      <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
              quotient  <= ERR_VAL;
              remainder <= ERR_VAL;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
              quotient  <= ERR_VAL;
              remainder <= ERR_VAL;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              div_zero <= 1'b0;
              overflow <= 1'b0;
              rem      <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
              lo       <= dividend[WIDTH-1:0];
              q_acc    <= '0;
              count    <= '0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= rem_next;
          lo    <= {lo[WIDTH-2:0], 1'b0};
          q_acc <= {q_acc[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          // Results are published only on the last iteration, never partially.
          if (count == CNT_W'(WIDTH - 1)) begin
            quotient  <= {q_acc[WIDTH-2:0], q_bit};
            remainder <= rem_next[WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: random and directed divides against an arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;
  logic        overflow;

  typedef struct {
    logic [31:0] dd;
    logic [15:0] dv;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  seq_divider #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] dd, input logic [15:0] dv);
    exp_t e;
    longint unsigned a, b;
    e.dd = dd; e.dv = dv; e.dz = 1'b0; e.ov = 1'b0; e.acc = 0;
    a = longint'(dd); b = longint'(dv);
    if (dv == 0) begin
      e.dz = 1'b1; e.q = 16'hFFFF; e.r = 16'hFFFF;
    end else if (a / b > 64'hFFFF) begin
      e.ov = 1'b1; e.q = 16'hFFFF; e.r = 16'hFFFF;
    end else begin
      e.q = 16'(a / b); e.r = 16'(a % b);
    end
    return e;
  endfunction

  // Monitor: latency on rise, stability while stalled, compare on handshake.
  logic        prev_v = 1'b0, hold_v = 1'b0;
  logic [15:0] h_q, h_r;
  logic        h_dz, h_ov;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0; hold_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) check("unexpected_result", 1, 0);
        else if (sb[0].dz || sb[0].ov) check("latency_err_le1", (cyc - sb[0].acc) <= 1, 1);
        else check("latency", cyc - sb[0].acc, 16);
      end
      if (hold_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_q_r", {quotient, remainder, div_zero, overflow}, {h_q, h_r, h_dz, h_ov});
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("flags", {div_zero, overflow}, {e.dz, e.ov});
        if (!e.dz && !e.ov) begin
          check("invariant", 64'(quotient) * 64'(e.dv) + 64'(remainder), 64'(e.dd));
          check("rem_lt_div", remainder < e.dv, 1);
        end
      end
      hold_v = out_valid && !out_ready;
      h_q = quotient; h_r = remainder; h_dz = div_zero; h_ov = overflow;
      prev_v = out_valid;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [31:0] dd, input logic [15:0] dv);
    int w = 0;
    bit ok = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = dd; divisor = dv;
    while (!ok && w < 500) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else w++;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      e = model(dd, dv);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; dividend = $urandom; divisor = 16'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || !in_ready) && w < 2000) begin
      @(negedge clk); w++;
    end
    if (w >= 2000) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dv, hi;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {quotient, remainder, div_zero, overflow}, 0);
    @(negedge clk); rst_n = 1'b1;

    issue(32'd100000, 16'd300);
    issue(32'd5, 16'd0);
    issue(32'h0001_0000, 16'd1);
    issue(32'hFFFE_0001, 16'hFFFF);
    issue(32'h1234_0000, 16'h1234);
    issue(32'h1233_FFFF, 16'h1234);
    issue(32'hFFFF_FFFF, 16'd0);
    drain();

    // Backpressure: stall the result, poke in_valid, then release.
    out_ready = 1'b0;
    issue(32'd777777, 16'd1000);
    begin
      int w = 0;
      while (!out_valid && w < 100) begin @(negedge clk); w++; end
      check("bp_valid_seen", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = i[0]; dividend = 32'd42; divisor = 16'd5;
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_after", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b1;
    issue(32'd42, 16'd5);
    drain();

    // Reset in the middle of a divide.
    issue(32'd123456, 16'd789);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_outputs", {quotient, remainder, div_zero, overflow}, 0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_stale", out_valid, 0);
    check("midrst_ready", in_ready, 1);

    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 4 == 0) dv = 16'($urandom_range(1, 15));
      else dv = 16'($urandom_range(1, 65535));
      hi = 16'($urandom_range(0, int'(dv) - 1));
      issue({hi, 16'($urandom)}, dv);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
